// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the arbitrating N:1 multiplexer.
//   ARB_RR / ARB_FIXED : arbitration mode selectors for the arb_mode parameter.
//   wrap_inc()         : index increment that wraps at a channel count.
package arb_mux_pkg;

    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

    // Next index after idx, wrapping n-1 back to 0.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/arb_mux_n_rr_arbiter.sv
// Combinational arbiter: picks one requester from req.
//   req        : per-channel request vector (already masked by eligibility/slot state).
//   ptr        : round-robin search start; ignored in fixed-priority mode.
//   grant      : one-hot grant, all zero when no request.
//   grant_idx  : encoded index of the granted channel (0 when none).
//   grant_valid: a grant was issued.
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int unsigned channels = 8,
    parameter int unsigned arb_mode = ARB_RR,
    localparam int unsigned sel_width = $clog2(channels)
) (
    input  logic [channels-1:0]  req,
    input  logic [sel_width-1:0] ptr,
    output logic [channels-1:0]  grant,
    output logic [sel_width-1:0] grant_idx,
    output logic                 grant_valid
);

    int unsigned start_idx;
    int unsigned cand;

    // Search channels in the order start, start+1, ..., wrapping at channels-1;
    // fixed priority is the same search anchored at 0.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 32'd0;
        start_idx   = (arb_mode == ARB_FIXED) ? 32'd0 : 32'(ptr);
        if (start_idx >= channels) begin
            start_idx = 32'd0;
        end
        for (int unsigned i = 0; i < channels; i++) begin
            cand = start_idx + i;
            if (cand >= channels) begin
                cand = cand - channels;
            end
            if (!grant_valid && req[cand[sel_width-1:0]]) begin
                grant_valid                  = 1'b1;
                grant[cand[sel_width-1:0]]   = 1'b1;
                grant_idx                    = cand[sel_width-1:0];
            end
        end
    end

endmodule

// File: rtl/arb_mux_n.sv
// N-channel arbitrating multiplexer with a one-entry registered output slot.
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset.
//   in_data      : flattened channel data, channel k at [k*bus_size +: bus_size].
//   in_valid     : per-channel request.
//   in_ready     : per-channel accept, at most one bit high (combinational).
//   force_sel_en : restrict eligibility to channel force_sel only.
//   force_sel    : forced channel index; values >= channels select nothing.
//   out_data     : data held in the slot.
//   out_channel  : channel index held in the slot.
//   out_valid    : slot holds data.
//   out_ready    : consumer accepts the slot this cycle.
module arb_mux_n
    import arb_mux_pkg::*;
#(
    parameter int unsigned bus_size = 32,
    parameter int unsigned channels = 8,
    parameter int unsigned arb_mode = ARB_RR,
    localparam int unsigned sel_width = $clog2(channels)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [channels*bus_size-1:0] in_data,
    input  logic [channels-1:0]          in_valid,
    output logic [channels-1:0]          in_ready,
    input  logic                         force_sel_en,
    input  logic [sel_width-1:0]         force_sel,
    output logic [bus_size-1:0]          out_data,
    output logic [sel_width-1:0]         out_channel,
    output logic                         out_valid,
    input  logic                         out_ready
);

    logic [bus_size-1:0]  ch_data [channels];
    logic [channels-1:0]  eligible;
    logic [channels-1:0]  req;
    logic [channels-1:0]  grant;
    logic [sel_width-1:0] grant_idx;
    logic                 grant_valid;
    logic                 load_ok;

    logic                 out_valid_q, out_valid_d;
    logic [bus_size-1:0]  out_data_q, out_data_d;
    logic [sel_width-1:0] out_channel_q, out_channel_d;
    logic [sel_width-1:0] ptr_q, ptr_d;

    // An out-of-range force_sel matches no channel, so nothing is eligible.
    for (genvar g = 0; g < channels; g++) begin : g_chan
        assign ch_data[g]  = in_data[g*bus_size +: bus_size];
        assign eligible[g] = in_valid[g] && (!force_sel_en || force_sel == sel_width'(g));
    end

    // Slot can take new data when empty or being drained in the same cycle.
    assign load_ok = !out_valid_q || out_ready;
    assign req     = load_ok ? eligible : '0;

    rr_arbiter #(
        .channels (channels),
        .arb_mode (arb_mode)
    ) u_arbiter (
        .req         (req),
        .ptr         (ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign in_ready = grant;

    always_comb begin
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_channel_d = out_channel_q;
        ptr_d         = ptr_q;
        if (load_ok) begin
            out_valid_d = grant_valid;
        end
        if (grant_valid) begin
            out_data_d    = ch_data[grant_idx];
            out_channel_d = grant_idx;
            // Forced grants must not disturb round-robin fairness.
            if (arb_mode == ARB_RR && !force_sel_en) begin
                ptr_d = sel_width'(wrap_inc(32'(grant_idx), channels));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_channel_q <= '0;
            ptr_q         <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_channel_q <= out_channel_d;
            ptr_q         <= ptr_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_channel = out_channel_q;

endmodule

// File: tb/tb_arb_mux_n.sv
// Bench for arb_mux_n: three instances (8-ch round-robin, 8-ch fixed, 5-ch round-robin)
// share stimulus; a reference model predicts grants and a monitor checks the slot outputs.
module tb_arb_mux_n;
    import arb_mux_pkg::*;

    typedef struct {
        int          ch;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] din [8];
    logic [255:0] in_flat;
    logic [7:0]  in_valid = '0;
    logic        force_en = 1'b0;
    logic [2:0]  force_sel = '0;
    logic        out_ready = 1'b0;

    logic [7:0]  ir_a, ir_b;
    logic [4:0]  ir_c;
    logic [31:0] od_a, od_b, od_c;
    logic [2:0]  oc_a, oc_b, oc_c;
    logic        ov_a, ov_b, ov_c;

    logic [7:0]  irv [3];
    logic [31:0] mdv [3];
    logic [2:0]  mcv [3];
    logic        mvv [3];

    int n_tests = 0;
    int n_fail  = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 8; g++) begin : g_flat
        assign in_flat[g*32 +: 32] = din[g];
    end

    arb_mux_n #(.bus_size(32), .channels(8), .arb_mode(ARB_RR)) u_rr8 (
        .clk(clk), .rst_n(rst_n), .in_data(in_flat), .in_valid(in_valid), .in_ready(ir_a),
        .force_sel_en(force_en), .force_sel(force_sel), .out_data(od_a), .out_channel(oc_a),
        .out_valid(ov_a), .out_ready(out_ready)
    );

    arb_mux_n #(.bus_size(32), .channels(8), .arb_mode(ARB_FIXED)) u_fx8 (
        .clk(clk), .rst_n(rst_n), .in_data(in_flat), .in_valid(in_valid), .in_ready(ir_b),
        .force_sel_en(force_en), .force_sel(force_sel), .out_data(od_b), .out_channel(oc_b),
        .out_valid(ov_b), .out_ready(out_ready)
    );

    arb_mux_n #(.bus_size(32), .channels(5), .arb_mode(ARB_RR)) u_rr5 (
        .clk(clk), .rst_n(rst_n), .in_data(in_flat[159:0]), .in_valid(in_valid[4:0]),
        .in_ready(ir_c), .force_sel_en(force_en), .force_sel(force_sel), .out_data(od_c),
        .out_channel(oc_c), .out_valid(ov_c), .out_ready(out_ready)
    );

    assign irv[0] = ir_a;
    assign irv[1] = ir_b;
    assign irv[2] = {3'b000, ir_c};
    assign mdv[0] = od_a;
    assign mdv[1] = od_b;
    assign mdv[2] = od_c;
    assign mcv[0] = oc_a;
    assign mcv[1] = oc_b;
    assign mcv[2] = oc_c;
    assign mvv[0] = ov_a;
    assign mvv[1] = ov_b;
    assign mvv[2] = ov_c;

    function automatic int n_of(input int d);
        return (d == 2) ? 5 : 8;
    endfunction

    function automatic int fixed_of(input int d);
        return (d == 1) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int d, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h, want 0x%0h at %0t", name, d, act, exp, $time);
        end
    endtask

    task automatic q_push(input int d, input exp_t e);
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int q_size(input int d);
        case (d)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic q_pop(input int d, output exp_t e);
        case (d)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    // Grant rule: forced channel if valid and in range; else first valid channel
    // scanning from the start point (0 for fixed priority) with wrap-around.
    function automatic int model_grant(input int n, input int fixed, input int ptr,
                                       input logic [7:0] v, input logic fen, input int fsel);
        int c;
        if (fen) return (fsel < n && v[fsel]) ? fsel : -1;
        for (int i = 0; i < n; i++) begin
            c = ((fixed != 0 ? 0 : ptr) + i) % n;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Reference model: evaluated mid-cycle with settled inputs, predicts the
    // accept for the coming edge and queues the data the slot must present.
    int m_ptr [3];
    bit m_valid [3];

    initial begin : model
        bit          load_ok;
        int          g;
        logic [7:0]  exp_ir;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int d = 0; d < 3; d++) begin
                    m_ptr[d]   = 0;
                    m_valid[d] = 1'b0;
                end
                q0.delete();
                q1.delete();
                q2.delete();
            end else begin
                for (int d = 0; d < 3; d++) begin
                    load_ok = !m_valid[d] || out_ready;
                    g = -1;
                    if (load_ok) begin
                        g = model_grant(n_of(d), fixed_of(d), m_ptr[d], in_valid, force_en,
                                        int'(force_sel));
                    end
                    exp_ir = (g >= 0) ? 8'(1 << g) : 8'h00;
                    check("in_ready", d, 64'(irv[d]), 64'(exp_ir));
                    if (load_ok) m_valid[d] = (g >= 0);
                    if (g >= 0) begin
                        e.ch   = g;
                        e.data = din[g];
                        q_push(d, e);
                        if (fixed_of(d) == 0 && !force_en) m_ptr[d] = (g + 1) % n_of(d);
                    end
                end
            end
        end
    end

    // Monitor: after each edge, a freshly presented slot must match the oldest
    // queued expectation; a stalled or drained slot must keep its last contents.
    initial begin : monitor
        logic        pv [3];
        logic        pr;
        logic        prst;
        exp_t        e;
        logic [31:0] last_d [3];
        logic [2:0]  last_c [3];
        for (int d = 0; d < 3; d++) begin
            last_d[d] = '0;
            last_c[d] = '0;
        end
        forever begin
            @(negedge clk);
            pr   = out_ready;
            prst = rst_n;
            for (int d = 0; d < 3; d++) pv[d] = mvv[d];
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                if (!rst_n || !prst) begin
                    last_d[d] = '0;
                    last_c[d] = '0;
                end else if (mvv[d] && (!pv[d] || pr)) begin
                    check("sb_expected", d, 64'(q_size(d) > 0), 64'd1);
                    if (q_size(d) > 0) begin
                        q_pop(d, e);
                        check("out_data", d, 64'(mdv[d]), 64'(e.data));
                        check("out_channel", d, 64'(mcv[d]), 64'(e.ch));
                        last_d[d] = e.data;
                        last_c[d] = 3'(e.ch);
                    end
                end else begin
                    check("held_data", d, 64'(mdv[d]), 64'(last_d[d]));
                    check("held_channel", d, 64'(mcv[d]), 64'(last_c[d]));
                    if (!mvv[d]) begin
                        check("sb_missing", d, 64'(q_size(d)), 64'd0);
                        while (q_size(d) > 0) q_pop(d, e);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rand_data();
        for (int k = 0; k < 8; k++) din[k] = $urandom;
    endtask

    task automatic rand_inputs();
        in_valid  = 8'($urandom);
        out_ready = ($urandom_range(0, 9) < 7);
        force_en  = ($urandom_range(0, 9) < 2);
        force_sel = 3'($urandom_range(0, 7));
        rand_data();
    endtask

    initial begin : driver
        rand_inputs();
        repeat (3) begin
            tick();
            rand_inputs();
        end
        in_valid  = '0;
        force_en  = 1'b0;
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            check("rst_valid", d, 64'(mvv[d]), 64'd0);
            check("rst_data", d, 64'(mdv[d]), 64'd0);
            check("rst_channel", d, 64'(mcv[d]), 64'd0);
            check("rst_in_ready", d, 64'(irv[d]), 64'd0);
        end
        tick();
        for (int d = 0; d < 3; d++) check("idle_valid", d, 64'(mvv[d]), 64'd0);

        // All channels valid: round-robin visits every channel in turn.
        in_valid = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("rr_seq8", 0, 64'(oc_a), 64'(k % 8));
            check("fix_all", 1, 64'(oc_b), 64'd0);
            check("rr_seq5", 2, 64'(oc_c), 64'(k % 5));
            check("rr_no_bubble", 0, 64'(ov_a), 64'd1);
            rand_data();
        end

        // Fixed priority: lowest valid index wins.
        in_valid = 8'b1010_0100;
        repeat (4) begin
            tick();
            check("fix_ch2", 1, 64'(oc_b), 64'd2);
            rand_data();
        end
        in_valid = 8'b1010_0000;
        tick();
        check("fix_ch5", 1, 64'(oc_b), 64'd5);

        // Backpressure: slot holds while the consumer stalls.
        in_valid = 8'h08;
        din[3]   = 32'hDEAD_BEEF;
        tick();
        check("bp_load_data", 0, 64'(od_a), 64'hDEAD_BEEF);
        check("bp_load_ch", 0, 64'(oc_a), 64'd3);
        out_ready = 1'b0;
        in_valid  = 8'hFF;
        rand_data();
        repeat (3) begin
            tick();
            check("bp_hold_data", 0, 64'(od_a), 64'hDEAD_BEEF);
            check("bp_hold_valid", 0, 64'(ov_a), 64'd1);
            check("bp_in_ready", 0, 64'(ir_a), 64'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_reload_ch", 0, 64'(oc_a), 64'd4);
        check("bp_reload_valid", 0, 64'(ov_a), 64'd1);

        // Forced select: only channel 6, pointer left alone.
        force_en  = 1'b1;
        force_sel = 3'd6;
        repeat (3) begin
            tick();
            check("force_ch6", 0, 64'(oc_a), 64'd6);
            check("force_oob5", 2, 64'(ov_c), 64'd0);
        end
        force_en = 1'b0;
        tick();
        check("force_ptr_kept", 0, 64'(oc_a), 64'd5);
        force_en  = 1'b1;
        force_sel = 3'd6;
        in_valid  = 8'hBF;
        tick();
        check("force_idle_valid", 0, 64'(ov_a), 64'd0);
        check("force_idle_ready", 0, 64'(ir_a), 64'd0);
        force_sel = 3'd7;
        in_valid  = 8'hFF;
        tick();
        check("force_ch7", 0, 64'(oc_a), 64'd7);
        check("force7_oob5", 2, 64'(ov_c), 64'd0);
        force_en = 1'b0;

        repeat (400) begin
            rand_inputs();
            tick();
        end

        // Asynchronous reset mid-stream.
        in_valid  = 8'hFF;
        force_en  = 1'b0;
        out_ready = 1'b1;
        tick();
        for (int d = 0; d < 3; d++) check("pre_reset_valid", d, 64'(mvv[d]), 64'd1);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) check("async_reset", d, 64'(mvv[d]), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;

        repeat (60) begin
            rand_inputs();
            tick();
        end
        in_valid  = '0;
        force_en  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_mux_n.md
Name: arb_mux_n

Overview:
- Parametrised N-channel arbitrating multiplexer; successor to the fixed 8:1 combinational select muxes.
- Adds per-channel valid/ready handshakes, round-robin or fixed-priority arbitration, an external forced-select override, and a one-entry registered output slot.
- Sits between multiple requesters (writeback sources, memory-return paths) and a single consumer in the pipeline.

Parameters:
- bus_size, 32: data width per channel.
- channels, 8: number of input channels, ≥2, need not be a power of 2.
- arb_mode, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- sel_width, $clog2(channels): derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  channels*bus_size  flattened channel data; channel k occupies bits [k*bus_size +: bus_size].
- in_valid  input  channels  per-channel request.
- in_ready  output  channels  per-channel accept; at most one bit high.
- force_sel_en  input  1  when 1, only channel force_sel is eligible.
- force_sel  input  sel_width  forced channel index.
- out_data  output  bus_size  registered selected data.
- out_channel  output  sel_width  index of the channel held in the slot.
- out_valid  output  1  slot holds data.
- out_ready  input  1  consumer accepts slot.

Behaviour:
- Reset (async assert, sync-release usage): out_valid=0, out_data=0, out_channel=0, rr pointer=0. Any slot contents are discarded. Reset mid-handshake drops the pending transfer with no partial state.
- load_ok = !out_valid || out_ready (slot empty or being drained this cycle).
- Eligible set:
  - force_sel_en=1: only force_sel, and only if in_valid[force_sel].
  - force_sel values ≥ channels: nothing eligible.
  - otherwise: all channels with in_valid set.
- Grant:
  - Combinational, computed only when load_ok and the eligible set is non-empty.
  - Fixed mode: lowest eligible index.
  - Round-robin mode: first eligible index searching ptr, ptr+1, …, channels-1, 0, …, ptr-1.
- in_ready[g]=1 only for the granted channel in that cycle; all others 0. in_ready is combinational from in_valid, force_*, out_valid and out_ready. Requesters must not make in_valid depend on in_ready.
- Transfer on channel g when in_valid[g] && in_ready[g]. At the next edge: out_data = channel g data, out_channel = g, out_valid = 1.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 transfer per cycle; simultaneous drain and load in the same cycle is required.
- Drain with no new grant: out_valid → 0. out_data and out_channel hold their last values.
- Stall (out_valid && !out_ready): out_data and out_channel held stable; in_ready all 0.
- RR pointer:
  - After a non-forced grant g, ptr = g+1, wrapping channels-1 → 0.
  - Forced grants and fixed mode leave ptr unchanged.
- No in_valid set: no grant, ptr unchanged.
- Arbitration is fair in round-robin mode: with all channels continuously valid and out_ready=1, each channel is granted once every channels cycles.

Decomposition:
- Package arb_mux_pkg holds:
  - ARB_RR=0 and ARB_FIXED=1 constants.
  - A function for the wrapped-increment index.
- Sub-module rr_arbiter, parametrised by channels and arb_mode:
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational.
- The top level holds the pointer register, slot registers and data select.

Test Plan:
- Reset: hold rst_n=0 with random inputs, then release → out_valid=0, out_data=0, out_channel=0, in_ready=0 until requests appear. Assert rst_n mid-stream → out_valid falls without waiting for clk.
- Round-robin fairness: channels=8, all in_valid=1, out_ready=1 → out_channel sequence 0,1,2,…,7,0 on consecutive cycles with no bubbles.
- Fixed priority: arb_mode=1, in_valid=8'b1010_0100 → grant channel 2 every cycle. Drop channel 2 → channel 5 granted.
- Backpressure: out_ready=0 for 3 cycles after a load of channel 3 data 0xDEADBEEF → out_data held at 0xDEADBEEF, in_ready=0. Raise out_ready → next grant loads in the same cycle.
- Forced select: force_sel_en=1, force_sel=6, in_valid=8'hFF → only channel 6 granted and ptr unchanged. force_sel=6 with in_valid[6]=0 → no grant, out_valid falls after drain.
- Non-power-of-2: channels=5, round-robin, all valid → sequence 0,1,2,3,4,0 (wrap at index 4). force_sel=7 → no grant.
